// File: rtl/cpu_defs.sv
// Shared CPU definitions for the fetch stage: reset address, PC step,
// instruction width and the 2-bit branch counter encodings.
package cpu_defs;

  localparam int          INSTR_W      = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] PC_INC       = 32'd4;

  // Two-bit saturating branch counter; the MSB is the taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // Saturating step of a branch counter toward the resolved outcome.
  function automatic ctr_t ctr_step(input ctr_t cur, input logic taken);
    ctr_t res;
    res = cur;
    if (taken) begin
      if (cur != ST) res = ctr_t'(cur + 2'b01);
    end else begin
      if (cur != SNT) res = ctr_t'(cur - 2'b01);
    end
    return res;
  endfunction

  // A counter is predicting taken when it is in either taken state.
  function automatic logic ctr_taken(input ctr_t cur);
    return (cur == WT) || (cur == ST);
  endfunction

endpackage

// File: rtl/branch_predictor_table.sv
// Direct-mapped branch history table (2-bit counters) plus branch target
// buffer. One combinational lookup port, one clocked update port.
// Only built when BHT_PREDICT_EN is defined.
module branch_predictor_table
  import cpu_defs::*;
#(
  parameter int BHT_IDX_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] lookup_pc,
  output logic               lookup_taken,
  output logic [INSTR_W-1:0] lookup_target,
  input  logic               upd_valid,
  input  logic [INSTR_W-1:0] upd_pc,
  input  logic               upd_taken,
  input  logic [INSTR_W-1:0] upd_target
);

  localparam int DEPTH = 1 << BHT_IDX_W;
  localparam int TAG_W = INSTR_W - BHT_IDX_W - 2;
  localparam int TGT_W = INSTR_W - 2;

  ctr_t             ctr_q    [DEPTH];
  logic             valid_q  [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [TGT_W-1:0] target_q [DEPTH];

  logic [BHT_IDX_W-1:0] lookup_idx;
  logic [TAG_W-1:0]     lookup_tag;
  logic [BHT_IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0]     upd_tag;
  logic                 upd_hit;
  ctr_t                 upd_ctr;
  logic                 unused_low_bits;

  assign lookup_idx = lookup_pc[BHT_IDX_W+1:2];
  assign lookup_tag = lookup_pc[INSTR_W-1:BHT_IDX_W+2];
  assign upd_idx    = upd_pc[BHT_IDX_W+1:2];
  assign upd_tag    = upd_pc[INSTR_W-1:BHT_IDX_W+2];

  // Byte-offset bits never take part in indexing or stored targets.
  assign unused_low_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  // Lookup reads the stored state, so a same-cycle update is not yet visible.
  always_comb begin
    lookup_taken  = 1'b0;
    lookup_target = {target_q[lookup_idx], 2'b00};
    if (valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag)) begin
      lookup_taken = ctr_taken(ctr_q[lookup_idx]);
    end
  end

  // New counter value: a branch that doesn't own the entry restarts from the
  // weak state matching its outcome instead of inheriting another branch's history.
  always_comb begin
    upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    if (upd_hit) begin
      upd_ctr = ctr_step(ctr_q[upd_idx], upd_taken);
    end else begin
      upd_ctr = upd_taken ? WT : WNT;
    end
  end

  // Table storage: cleared on reset, written by resolved conditional branches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i]    <= WNT;
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (upd_valid) begin
      ctr_q[upd_idx] <= upd_ctr;
      if (upd_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target[INSTR_W-1:2];
      end
    end
  end

endmodule

// File: rtl/if_pc_predict.sv
// IF-stage PC generator: holds the fetch PC, drives the instruction-memory
// address and chooses the next PC from redirect, stall, prediction or +4.
// Prediction hardware is present only when BHT_PREDICT_EN is defined;
// otherwise fetch is purely sequential and the update port is ignored.
module if_pc_predict
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          BHT_IDX_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [INSTR_W-1:0] redirect_pc,
  input  logic               upd_valid,
  input  logic [INSTR_W-1:0] upd_pc,
  input  logic               upd_taken,
  input  logic [INSTR_W-1:0] upd_target,
  output logic [INSTR_W-1:0] pc_if,
  output logic               branch_predict_if
);

  logic [INSTR_W-1:0] pc_next;
  logic [INSTR_W-1:0] pc_seq;
  logic [INSTR_W-1:0] redirect_aligned;
  logic [INSTR_W-1:0] pred_target;
  logic               pred_taken;
  logic               unused_redirect_low;

  assign pc_seq              = pc_if + PC_INC;
  assign redirect_aligned    = {redirect_pc[INSTR_W-1:2], 2'b00};
  assign unused_redirect_low = ^redirect_pc[1:0];

`ifdef BHT_PREDICT_EN
  branch_predictor_table #(
    .BHT_IDX_W (BHT_IDX_W)
  ) u_table (
    .clk           (clk),
    .rst_n         (rst_n),
    .lookup_pc     (pc_if),
    .lookup_taken  (pred_taken),
    .lookup_target (pred_target),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target)
  );
`else
  logic                 unused_upd;
  logic [BHT_IDX_W-1:0] unused_idx;

  assign pred_taken  = 1'b0;
  assign pred_target = pc_seq;
  assign unused_upd  = ^{upd_valid, upd_pc, upd_taken, upd_target};
  assign unused_idx  = pc_if[BHT_IDX_W+1:2];
`endif

  assign branch_predict_if = pred_taken;

  // Next-PC priority: EX redirect wins over a stall, a stall wins over prediction.
  always_comb begin
    pc_next = pc_seq;
    if (redirect) begin
      pc_next = redirect_aligned;
    end else if (stall) begin
      pc_next = pc_if;
    end else if (pred_taken) begin
      pc_next = {pred_target[INSTR_W-1:2], 2'b00};
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_if <= RESET_PC;
    end else begin
      pc_if <= pc_next;
    end
  end

endmodule
